// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states and frame constants.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int          PS2_FRAME_BITS = 11;
    localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the PS/2 pins plus a falling-edge detector on the clock line.
module ps2_sync_edge (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_sync
);

    // [0],[1] synchronise; [2] holds the previous synchronised value for edge detection
    logic [2:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign clk_fall  = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_sync = data_sync_q[1];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: validates start/parity/stop, aborts stalled frames,
// and counts frame errors with saturation.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       data_ready,
    output logic [7:0] scancode,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic clk_fall;
    logic data_bit;

    ps2_sync_edge u_sync (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_fall  (clk_fall),
        .data_sync (data_bit)
    );

    ps2_state_e       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]       scancode_q, scancode_d;
    logic             data_ready_q, data_ready_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             timeout;

    assign timeout = (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        parity_d     = parity_q;
        scancode_d   = scancode_q;
        data_ready_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == IDLE || clk_fall) idle_cnt_d = '0;
        else                              idle_cnt_d = idle_cnt_q + CNT_W'(1);

        // Edge is checked before timeout so a coincident edge always wins
        unique case (state_q)
            IDLE: begin
                if (clk_fall && !data_bit) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (clk_fall) begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end else if (timeout) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            PARITY: begin
                if (clk_fall) begin
                    parity_d = data_bit;
                    state_d  = STOP;
                end else if (timeout) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            STOP: begin
                if (clk_fall) begin
                    state_d = IDLE;
                    if (data_bit && ((^shift_q) ^ parity_q)) begin
                        scancode_d   = shift_q;
                        data_ready_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        err_cnt_d = err_cnt_q;
        if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            idle_cnt_q   <= '0;
            scancode_q   <= '0;
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            idle_cnt_q   <= idle_cnt_d;
            scancode_q   <= scancode_d;
            data_ready_q <= data_ready_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign data_ready = data_ready_q;
    assign scancode   = scancode_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed plus randomized frame stimulus for ps2_frame_rx, checked against a frame-level model.
module tb_ps2_frame_rx;
    import ps2_pkg::*;

    localparam int TO   = 64;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       data_ready;
    logic [7:0] scancode;
    logic       frame_err;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int dr_cnt   = 0;
    int fe_cnt   = 0;
    logic [7:0] sc_at_dr = '0;

    logic [7:0] exp_sc  = '0;
    int         exp_err = 0;

    always #5 clk = ~clk;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_ready (data_ready),
        .scancode   (scancode),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    always @(negedge clk) begin
        if (data_ready === 1'b1) begin
            dr_cnt++;
            sc_at_dr = scancode;
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (data_ready === 1'b1 || frame_err === 1'b1) begin
            n_checks++;
            assert (!(data_ready === 1'b1 && frame_err === 1'b1)) else begin
                n_fail++;
                $error("FAIL strobe_overlap: observed data_ready=%b frame_err=%b required not both 1",
                       data_ready, frame_err);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par, input logic stp);
        return {stp, par, b, 1'b0};
    endfunction

    function automatic logic odd_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF + 12) @(negedge clk);
    endtask

    // Model: a frame is good iff stop=1 and data plus parity has an odd number of ones
    task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int  dr0 = dr_cnt;
        int  fe0 = fe_cnt;
        bit  good = !bad_par && !bad_stop;
        logic par = odd_par(b) ^ logic'(bad_par);
        send_bits(mk_frame(b, par, !bad_stop), PS2_FRAME_BITS);
        if (good) exp_sc = b;
        else if (exp_err < 255) exp_err++;
        chk({tag, "_dr"}, 32'(dr_cnt - dr0), good ? 32'd1 : 32'd0);
        chk({tag, "_fe"}, 32'(fe_cnt - fe0), good ? 32'd0 : 32'd1);
        chk({tag, "_sc"}, 32'(scancode), 32'(exp_sc));
        chk({tag, "_ec"}, 32'(err_count), 32'(exp_err));
        if (good) chk({tag, "_sc_at_pulse"}, 32'(sc_at_dr), 32'(b));
    endtask

    initial begin
        int dr0;
        int fe0;
        clrn     = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_dr", 32'(data_ready), 32'd0);
        chk("rst_fe", 32'(frame_err), 32'd0);
        chk("rst_sc", 32'(scancode), 32'd0);
        chk("rst_ec", 32'(err_count), 32'd0);
        clrn = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_dr", 32'(dr_cnt), 32'd0);
        chk("post_rst_fe", 32'(fe_cnt), 32'd0);

        do_frame("valid_1c", 8'h1C, 1'b0, 1'b0);
        do_frame("b2b_f0", PS2_BREAK_CODE, 1'b0, 1'b0);
        do_frame("b2b_1c", 8'h1C, 1'b0, 1'b0);
        do_frame("bad_par", 8'h1C, 1'b1, 1'b0);
        do_frame("bad_stop", 8'h1C, 1'b0, 1'b1);

        // Stalled frame: start plus four data bits, then the clock line goes quiet
        dr0 = dr_cnt;
        fe0 = fe_cnt;
        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 5);
        repeat (TO + 10) @(negedge clk);
        exp_err++;
        chk("to_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("to_dr", 32'(dr_cnt - dr0), 32'd0);
        chk("to_ec", 32'(err_count), 32'(exp_err));
        chk("to_state", 32'(dut.state_q), 32'(IDLE));
        do_frame("after_to_29", 8'h29, 1'b0, 1'b0);

        // Reset in the middle of a frame
        dr0 = dr_cnt;
        send_bits(mk_frame(8'h77, odd_par(8'h77), 1'b1), 6);
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        clrn    = 1'b1;
        exp_sc  = '0;
        exp_err = 0;
        repeat (10) @(negedge clk);
        chk("midrst_dr", 32'(dr_cnt - dr0), 32'd0);
        chk("midrst_sc", 32'(scancode), 32'd0);
        chk("midrst_ec", 32'(err_count), 32'd0);
        do_frame("after_rst_45", 8'h45, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] b = 8'($urandom);
            int kind = int'($urandom_range(0, 9));
            do_frame("rand", b, kind == 7 || kind == 9, kind >= 8);
        end

        dr0 = dr_cnt;
        for (int k = 0; k < 300; k++) begin
            logic [7:0] b = 8'($urandom);
            do_frame("sat", b, 1'b1, 1'b0);
        end
        chk("sat_ec", 32'(err_count), 32'd255);
        chk("sat_dr", 32'(dr_cnt - dr0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

Receives raw PS/2 device-to-host frames on the `ps2_clk`/`ps2_data` pins and delivers validated 8-bit scan codes to the key-event stage downstream. Each good byte produces a one-cycle `data_ready` strobe with `scancode` held stable afterwards. Malformed or stalled frames are dropped, flagged and counted. The block sits between the board PS/2 pins and the key processor, whose `data_ready`/`scancode` inputs it drives directly.

## Interface
- `TIMEOUT_CYCLES`, default 10000: system clocks with no `ps2_clk` falling edge, while mid-frame, before the frame is aborted (200 us at 50 MHz).
- `clk` input 1: system clock.
- `clrn` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous, idles high.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous, idles high.
- `data_ready` output 1: one-cycle pulse; a valid byte is on `scancode`.
- `scancode` output 8: last valid byte received; holds until the next valid frame.
- `frame_err` output 1: one-cycle pulse on a parity error, a stop-bit error or a timeout.
- `err_count` output 8: count of `frame_err` pulses, saturating at 255.

## Operation
- **Reset.** All outputs are 0, state is IDLE, and the shift register and bit counter are 0. Synchroniser and edge-history flops reset to 1 so that no false edge appears after reset.
- **Synchronisation.** Both pins pass through 2 flops. A third flop on the clock path gives edge detection: falling edge = previous 1 and current 0. Data is sampled from the synchronised `ps2_data` in the edge cycle.
- **Frame format.** 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1).
- **FSM states:**
  - IDLE: an edge with data=0 goes to DATA with the bit counter at 0. An edge with data=1 is ignored; the FSM stays in IDLE with no error.
  - DATA: each edge shifts the data bit in at the MSB and shifts right. After the 8th bit, go to PARITY.
  - PARITY: an edge captures the parity bit and goes to STOP.
  - STOP: on the edge, check stop==1 and that the XOR of the 8 data bits and the parity bit is 1. If both hold, load `scancode` and pulse `data_ready`; otherwise pulse `frame_err` and leave `scancode` unchanged. Go to IDLE in both cases.
- **Timeout.** In DATA, PARITY or STOP, an idle counter increments every cycle and clears on each edge. When it reaches `TIMEOUT_CYCLES-1`, go to IDLE and pulse `frame_err`. In IDLE the counter is held at 0.
- **Simultaneous events.** If an edge and the timeout occur in the same cycle, the edge wins and the timeout is not taken.
- **Error counter.** `err_count` increments on each `frame_err` and holds at 255.
- **Reset mid-frame.** The partial frame is discarded and no strobe is produced.
- **No back-pressure.** The consumer must accept `data_ready` in the cycle it is asserted.

## Timing
- Pin to edge detect: a falling edge on the `ps2_clk` pin is seen 2–3 `clk` cycles later, depending on phase.
- `scancode` and `data_ready` update on the same `clk` edge, in the cycle after the stop-bit edge-detect cycle. `data_ready` is high for exactly 1 cycle.
- `frame_err` follows the same 1-cycle-after rule for parity/stop errors. For timeouts it asserts in the cycle after the counter hits its limit.
- Back-to-back frames are supported. The PS/2 bit period is at least 60 us, far longer than the internal latency.
- `data_ready` and `frame_err` are never high in the same cycle.

## Structure
- **Shared package `ps2_pkg`:**
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - `PS2_FRAME_BITS = 11`.
  - `PS2_BREAK_CODE = 8'hF0`, also used by the key stage.
- **Sub-module `ps2_sync_edge`:** 2-flop synchroniser for both lines plus the falling-edge detector. Outputs are `clk_fall`, `data_sync`.
- **Top level:** FSM, shift register, timeout counter and error counter.

## Test plan
- **Reset values.** Hold `clrn` low with pins high → all outputs 0, and no `data_ready` for 20 cycles after release.
- **Valid frame.** Frame 0x1C with parity 0 → exactly one `data_ready` pulse, `scancode` = 0x1C, `err_count` = 0.
- **Back-to-back frames.** Frames F0 then 1C → two `data_ready` pulses; `scancode` reads F0 at the first and 1C at the second.
- **Parity and stop errors.** Frame 0x1C with parity 1 → `frame_err` pulse, no `data_ready`, `scancode` keeps its previous value, `err_count` = 1. Then the same byte with stop = 0 → `err_count` = 2.
- **Timeout recovery.** Start bit plus 4 data bits, then `ps2_clk` held high for `TIMEOUT_CYCLES` → `frame_err` pulse and state IDLE. The following valid 0x29 frame → `scancode` = 0x29.
- **Reset mid-frame and saturation.**
  - Assert `clrn` after 6 bits, release, send a valid 0x45 frame → one `data_ready` with 0x45.
  - 300 bad-parity frames → `err_count` = 255.
